// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PLL reset, qualifies its lock output and reports clocks_ready, fault and lock-loss status
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 500000,
    parameter int MAX_RETRIES      = 4,
    parameter int CNT_W            = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       clocks_ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] seq_state
);
    typedef enum logic [2:0] {
        RESET_PLL   = 3'd0,
        WAIT_LOCK   = 3'd1,
        STABLE_WAIT = 3'd2,
        RUN         = 3'd3,
        FAULT       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [3:0]       MAX_R     = 4'(MAX_RETRIES);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_n;
    logic [7:0]       loss_n;
    logic             sync1, locked_s;

    // two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) {locked_s, sync1} <= 2'b00;
        else      {locked_s, sync1} <= {sync1, pll_locked};
    end

    // next state, retry and lock-loss bookkeeping; soft reset overrides everything
    always_comb begin
        state_n = state;
        retry_n = retry_cnt;
        loss_n  = lock_loss_cnt;
        if (soft_reset_req) begin
            state_n = RESET_PLL;
            retry_n = '0;
        end else begin
            case (state)
                RESET_PLL:   if (cnt == RST_LAST) state_n = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) state_n = STABLE_WAIT;
                    else if (cnt == TO_LAST) begin
                        retry_n = retry_cnt + 4'd1;
                        state_n = (retry_n == MAX_R) ? FAULT : RESET_PLL;
                    end
                end
                STABLE_WAIT: begin
                    if (!locked_s) state_n = WAIT_LOCK;
                    else if (cnt == STAB_LAST) begin
                        state_n = RUN;
                        retry_n = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_n = RESET_PLL;
                        loss_n  = (lock_loss_cnt == 8'hFF) ? lock_loss_cnt : lock_loss_cnt + 8'd1;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // state, shared cycle counter (restarts on any transition or soft reset) and status counters
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_n;
            cnt           <= (soft_reset_req || state_n != state) ? '0 :
                             (state == RUN || state == FAULT) ? cnt : cnt + CNT_W'(1);
            retry_cnt     <= retry_n;
            lock_loss_cnt <= loss_n;
        end
    end

    assign pll_rst      = (state == RESET_PLL) || (state == FAULT);
    assign clocks_ready = (state == RUN);
    assign fault        = (state == FAULT);
    assign seq_state    = state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: randomized scoreboard bench against a time-based reference model of the lock sequencer
module tb_pll_lock_sequencer;
    localparam int RP = 4, ST = 8, TO = 32, MR = 2;
    localparam int S_RST = 0, S_WAIT = 1, S_STAB = 2, S_RUN = 3, S_FAULT = 4;
    localparam logic [17:0] RST_VEC = 18'h20000;

    logic       refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, soft_reset_req = 1'b0;
    logic       pll_rst, clocks_ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] seq_state;
    logic [17:0] dut_vec;

    pll_lock_sequencer #(
        .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(ST), .LOCK_TIMEOUT_CYC(TO),
        .MAX_RETRIES(MR), .CNT_W(8)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
        .pll_rst(pll_rst), .clocks_ready(clocks_ready), .fault(fault),
        .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .seq_state(seq_state)
    );

    assign dut_vec = {pll_rst, clocks_ready, fault, retry_cnt, lock_loss_cnt, seq_state};

    always #5 refclk = ~refclk;

    int total = 0, passed = 0;
    int m_phase, m_enter, m_cyc, m_retry, m_loss;
    bit hist[$];
    logic [17:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    endtask

    function automatic void model_reset();
        m_phase = S_RST; m_enter = 0; m_cyc = 0; m_retry = 0; m_loss = 0;
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endfunction

    function automatic void go(input int p);
        m_phase = p;
        m_enter = m_cyc + 1;
    endfunction

    function automatic int e_next();
        return m_cyc - m_enter;
    endfunction

    // one refclk edge of the reference: elapsed time in a phase, lock seen two edges late
    function automatic void model_edge(input bit lk, input bit sr);
        int e;
        bit ls;
        e  = m_cyc - m_enter;
        ls = hist.pop_front();
        hist.push_back(lk);
        if (sr) begin
            go(S_RST);
            m_retry = 0;
        end else if (m_phase == S_RST) begin
            if (e == RP - 1) go(S_WAIT);
        end else if (m_phase == S_WAIT) begin
            if (ls) go(S_STAB);
            else if (e == TO - 1) begin
                m_retry++;
                go(m_retry == MR ? S_FAULT : S_RST);
            end
        end else if (m_phase == S_STAB) begin
            if (!ls) go(S_WAIT);
            else if (e == ST - 1) begin
                go(S_RUN);
                m_retry = 0;
            end
        end else if (m_phase == S_RUN && !ls) begin
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            go(S_RST);
        end
        m_cyc++;
    endfunction

    function automatic logic [17:0] model_out();
        return {m_phase == S_RST || m_phase == S_FAULT, m_phase == S_RUN, m_phase == S_FAULT,
                4'(m_retry), 8'(m_loss), 3'(m_phase)};
    endfunction

    task automatic step(input bit lk, input bit sr);
        pll_locked = lk;
        soft_reset_req = sr;
        @(posedge refclk);
        model_edge(lk, sr);
        exp_q.push_back(model_out());
        @(negedge refclk);
        soft_reset_req = 1'b0;
    endtask

    task automatic run_to_run();
        int n = 0;
        while (m_phase != S_RUN && n < 100) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("reach_run", clocks_ready, 1);
    endtask

    // monitor: every cycle the DUT presents its status, compare against the oldest expectation
    always @(negedge refclk) begin
        if (exp_q.size() != 0) begin
            logic [17:0] x;
            x = exp_q.pop_front();
            check("outputs", dut_vec, x);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        #2 rst = 1'b0;
        @(negedge refclk);
        #1 check("reset_vec", dut_vec, RST_VEC);
        @(negedge refclk);
        rst = 1'b1;

        // nominal lock: raise at edge 10, ready after edge 20
        repeat (10) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        check("ready_early", clocks_ready, 0);
        step(1'b1, 1'b0);
        check("ready_edge20", clocks_ready, 1);
        check("nominal_retry", retry_cnt, 0);

        // lose lock, then bounce inside the stability window
        repeat (3) step(1'b0, 1'b0);
        n = 0;
        while (!(m_phase == S_STAB && e_next() == 5) && n < 100) begin
            step(m_phase == S_RST ? 1'b0 : 1'b1, 1'b0);
            n++;
        end
        repeat (3) step(1'b0, 1'b0);
        check("bounce_state", seq_state, 1);
        n = 0;
        do begin
            step(1'b1, 1'b0);
            n++;
        end while (!clocks_ready && n < 40);
        check("bounce_latency", n, 11);
        check("bounce_retry", retry_cnt, 0);

        // two timeouts exhaust the retries
        repeat (100) step(1'b0, 1'b0);
        check("fault_flag", fault, 1);
        check("fault_retry", retry_cnt, 2);
        check("fault_pll_rst", pll_rst, 1);
        step(1'b0, 1'b1);
        check("soft_fault_clr", fault, 0);
        check("soft_retry_clr", retry_cnt, 0);
        n = 0;
        while (pll_rst && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("soft_pulse_len", n, 4);

        // soft reset on the same edge as the second timeout
        n = 0;
        while (!(m_retry == 1 && m_phase == S_WAIT && e_next() == TO - 1) && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("prio_pre_retry", retry_cnt, 1);
        step(1'b0, 1'b1);
        check("prio_retry", retry_cnt, 0);
        check("prio_state", seq_state, 0);

        // repeated lock loss in RUN saturates the loss counter
        for (int i = 0; i < 300; i++) begin
            if (total - passed > 50) break;
            run_to_run();
            repeat ($urandom_range(0, 3)) step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'(($urandom_range(0, 1))), 1'b0);
            check("loss_ready_held", clocks_ready, 1);
            step(1'(($urandom_range(0, 1))), 1'b0);
            check("loss_ready_drop", clocks_ready, 0);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        end
        check("loss_saturated", lock_loss_cnt, 255);

        // random lock noise with occasional soft resets
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 60) == 0));

        // asynchronous reset between edges while in the stability window
        step(1'b0, 1'b1);
        n = 0;
        while (!(m_phase == S_STAB && e_next() == 3) && n < 100) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("pre_arst_state", seq_state, 2);
        #3 rst = 1'b0;
        #1 check("arst_vec", dut_vec, RST_VEC);
        pll_locked = 1'b0;
        @(negedge refclk);
        check("arst_hold", dut_vec, RST_VEC);
        rst = 1'b1;
        model_reset();
        repeat (30) step(1'b1, 1'b0);
        check("arst_relock", clocks_ready, 1);
        check("arst_loss", lock_loss_cnt, 0);

        @(negedge refclk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the ADC clock PLL on the 50 MHz reference clock.
- Drives the PLL reset and qualifies its lock output with a synchroniser and a stability window.
- Retries relock on timeout and latches a fault after too many failed attempts.
- Outputs a clean clocks_ready flag and a lock-loss counter for the downstream ADC capture and timing logic.

Parameters:
- RST_PULSE_CYC, 16: refclk cycles pll_rst is held high per reset attempt (>=1).
- LOCK_STABLE_CYC, 1024: consecutive cycles of synchronised lock required before RUN (>=1).
- LOCK_TIMEOUT_CYC, 500000: cycles allowed in WAIT_LOCK before an attempt fails (10 ms at 50 MHz).
- MAX_RETRIES, 4: failed attempts allowed before FAULT (1..15).
- CNT_W, 20: shared cycle counter width; must hold max(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC).

Ports:
- refclk, input, 1: single clock, 50 MHz PLL reference.
- rst, input, 1: asynchronous, active-low reset.
- pll_locked, input, 1: raw PLL locked output, asynchronous to refclk.
- soft_reset_req, input, 1: one-cycle request to restart the sequence from any state.
- pll_rst, output, 1: PLL reset, active high.
- clocks_ready, output, 1: PLL outputs are valid and stable.
- fault, output, 1: retries exhausted; sticky until soft_reset_req or rst.
- retry_cnt, output, 4: failed attempts since the last success or soft reset.
- lock_loss_cnt, output, 8: lock drops seen while in RUN; saturates at 255.
- seq_state, output, 3: current state encoding, for status readback.

Behaviour:
- Reset (rst=0, async): state=RESET_PLL, counter=0, pll_rst=1, clocks_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, seq_state=0, sync flops=0.
- pll_locked passes through a 2-flop synchroniser. locked_s is the second flop.
- Outputs are decoded from the state register only (Moore, no added latency):
  - pll_rst=1 in RESET_PLL and FAULT.
  - clocks_ready=1 only in RUN.
  - fault=1 only in FAULT.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE_WAIT=2, RUN=3, FAULT=4.
- Single counter, cleared on every state transition.
- RESET_PLL:
  - Counter increments each cycle.
  - At counter==RST_PULSE_CYC-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE_CYC cycles.
- WAIT_LOCK:
  - locked_s=1: go to STABLE_WAIT.
  - Otherwise, at counter==LOCK_TIMEOUT_CYC-1, increment retry_cnt. If the new value equals MAX_RETRIES, go to FAULT; else go to RESET_PLL.
  - If locked_s=1 on the timeout cycle, lock wins (no retry counted).
- STABLE_WAIT:
  - locked_s=0: go to WAIT_LOCK with the timeout restarted; retry_cnt unchanged.
  - locked_s=1 at counter==LOCK_STABLE_CYC-1: go to RUN and clear retry_cnt.
- Lock-up latency: clocks_ready rises exactly LOCK_STABLE_CYC+2 refclk edges after the first edge at which pll_locked is sampled high by the first synchroniser flop, provided pll_locked stays high.
- RUN:
  - locked_s=0: lock_loss_cnt += 1 (saturating at 255), go to RESET_PLL. clocks_ready drops on that edge.
  - Lock-drop detection latency is 3 edges from raw pll_locked falling.
- FAULT: hold until soft_reset_req. lock_loss_cnt is unaffected.
- soft_reset_req=1 in any state: go to RESET_PLL with counter=0 and retry_cnt=0; fault clears.
  - This has priority over every other transition in the same cycle.
  - lock_loss_cnt is not cleared (only rst clears it).
- Reset mid-operation: rst asserted in any state immediately forces the reset values. After rst deasserts, sequencing restarts at RESET_PLL.
- Glitches on pll_locked shorter than one refclk period may be missed. That is acceptable; the STABLE_WAIT window filters any that are caught.

Test Plan (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRIES=2):
- Nominal lock:
  - Stimulus: release rst; pll_locked=0. Raise pll_locked at edge 10 and hold it.
  - Required: pll_rst=1 for edges 0–3; seq_state=1 from edge 4; clocks_ready=1 from edge 20; retry_cnt=0.
- Lock bounce:
  - Stimulus: in STABLE_WAIT at counter=5, drop pll_locked for 3 cycles, then raise it again.
  - Required: return to WAIT_LOCK; no retry counted; clocks_ready rises 10 edges after the re-rise is sampled.
- Timeout and fault:
  - Stimulus: pll_locked held at 0.
  - Required: first attempt times out → retry_cnt=1 and pll_rst pulses 4 cycles; second timeout → retry_cnt=2, fault=1, pll_rst stays 1.
  - Then pulse soft_reset_req → fault=0, retry_cnt=0, pll_rst high for exactly 4 cycles.
- Loss in RUN:
  - Stimulus: in RUN, drop pll_locked.
  - Required: clocks_ready falls 3 edges later; lock_loss_cnt=1; new reset pulse; re-lock returns to RUN.
  - Repeat 300 times → lock_loss_cnt=255.
- Priority and async reset:
  - Stimulus 1: assert soft_reset_req on the same cycle as a WAIT_LOCK timeout.
  - Required: RESET_PLL with retry_cnt=0.
  - Stimulus 2: assert rst mid-STABLE_WAIT, between edges.
  - Required: all outputs reach reset values without waiting for a refclk edge.
